// File: rtl/mult32_seq_ctrl.sv
// mult32_seq_ctrl: sequences a 32x32 multiply through an external 16x16
// multiplier in four slice cycles. Each slice product comes back
// combinationally on mul_C and is added into a 64-bit accumulator at its
// weight. Operands are taken on an in_valid/in_ready handshake, and the
// product is offered on an out_valid/out_ready handshake.
module mult32_seq_ctrl #(
  parameter int CHOP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              a_sign,
  input  logic              b_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       p,
  output logic [CHOP-1:0]   mul_A,
  output logic [CHOP-1:0]   mul_B,
  output logic              mul_A_sign,
  output logic              mul_B_sign,
  output logic              mul_HALF_0,
  input  logic [2*CHOP-1:0] mul_C,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [31:0] a_q, b_q;
  logic        a_sign_q, b_sign_q;
  logic [63:0] acc;
  logic        accept;
  logic        slice_cycle;
  logic [5:0]  shamt;
  logic [63:0] c_ext;
  logic [63:0] term;

  assign accept      = (state == IDLE) && in_valid;
  assign slice_cycle = (state == S0) || (state == S1) || (state == S2) || (state == S3);

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign p          = acc;
  assign mul_HALF_0 = 1'b0;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: fixed walk through the four slices, then wait for
  // the consumer to take the product.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = S0;
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice operand drive and accumulation weight for the current state.
  // Only the upper halves carry the operand's sign. The lower halves are
  // always unsigned digits.
  always_comb begin
    mul_A      = '0;
    mul_B      = '0;
    mul_A_sign = 1'b0;
    mul_B_sign = 1'b0;
    shamt      = '0;
    case (state)
      S0: begin
        mul_A = a_q[CHOP-1:0];
        mul_B = b_q[CHOP-1:0];
      end
      S1: begin
        mul_A      = a_q[2*CHOP-1:CHOP];
        mul_B      = b_q[CHOP-1:0];
        mul_A_sign = a_sign_q;
        shamt      = 6'(CHOP);
      end
      S2: begin
        mul_A      = a_q[CHOP-1:0];
        mul_B      = b_q[2*CHOP-1:CHOP];
        mul_B_sign = b_sign_q;
        shamt      = 6'(CHOP);
      end
      S3: begin
        mul_A      = a_q[2*CHOP-1:CHOP];
        mul_B      = b_q[2*CHOP-1:CHOP];
        mul_A_sign = a_sign_q;
        mul_B_sign = b_sign_q;
        shamt      = 6'(2 * CHOP);
      end
      default: ;
    endcase
  end

  // A slice product is signed whenever either of its operands is signed.
  assign c_ext = (mul_A_sign || mul_B_sign)
               ? {{(64 - 2*CHOP){mul_C[2*CHOP-1]}}, mul_C}
               : {{(64 - 2*CHOP){1'b0}}, mul_C};
  assign term  = c_ext << shamt;

  // Operand capture on accept and modulo-2^64 accumulation during slices.
  // NOTE: the latched operands and the accumulator are reset along with the
  // FSM, so p reads 0 after reset and a discarded operation leaves nothing
  // behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      acc      <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      a_sign_q <= a_sign;
      b_sign_q <= b_sign;
      acc      <= '0;
    end else if (slice_cycle) begin
      acc <= acc + term;
    end
  end

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Self-checking bench for mult32_seq_ctrl. The external 16x16 multiplier is
// modelled behaviourally here. Expected products come from full-width
// arithmetic on the sign-extended operands. A driver pushes expectations
// at each accept, and an independent monitor pops and compares them as
// products are handed over.
module tb_mult32_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        a_sign, b_sign;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] p;
  logic [15:0] mul_A, mul_B;
  logic        mul_A_sign, mul_B_sign, mul_HALF_0;
  logic [31:0] mul_C;
  logic        busy;

  mult32_seq_ctrl #(.CHOP(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .a_sign     (a_sign),
    .b_sign     (b_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p),
    .mul_A      (mul_A),
    .mul_B      (mul_B),
    .mul_A_sign (mul_A_sign),
    .mul_B_sign (mul_B_sign),
    .mul_HALF_0 (mul_HALF_0),
    .mul_C      (mul_C),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 16x16 multiplier: exact product of the operands under their sign flags.
  logic [63:0] ma_ext, mb_ext, mprod;
  always_comb begin
    ma_ext = mul_A_sign ? {{48{mul_A[15]}}, mul_A} : {48'b0, mul_A};
    mb_ext = mul_B_sign ? {{48{mul_B[15]}}, mul_B} : {48'b0, mul_B};
    mprod  = ma_ext * mb_ext;
    mul_C  = mprod[31:0];
  end

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   rdy_rand    = 1'b0;
  bit   rdy_force   = 1'b1;
  bit   prev_ov     = 1'b0;

  always @(posedge clk) cyc++;

  // Consumer: random or directed out_ready, updated just after each edge.
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic xs, input logic ys);
    logic [63:0] xe, ye;
    xe = xs ? {{32{x[31]}}, x} : {32'b0, x};
    ye = ys ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: latency of each product, then product value at the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) fail("spurious_out_valid");
        else check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'd4);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("product", p, e.prod);
        check("mul_HALF_0", {63'b0, mul_HALF_0}, 64'd0);
      end
    end
    prev_ov = out_valid;
  end

  // Present one operand set and hold it until accepted. Returns just after the accept edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tas, input logic tbs);
    exp_t e;
    bit   done = 1'b0;
    in_valid = 1'b1;
    a = ta; b = tb; a_sign = tas; b_sign = tbs;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.prod    = ref_prod(ta, tb, tas, tbs);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) fail("accept_timeout");
    in_valid = 1'b0;
    a = $urandom; b = $urandom; a_sign = 1'($urandom); b_sign = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && in_ready;
    end
    if (!ok) fail("idle_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [33:0] slice_exp [4];
  logic [63:0] bp_exp;
  bit          seen;

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_out_valid_busy", {62'b0, out_valid, busy}, 64'd0);
    check("reset_p", p, 64'd0);
    check("reset_mul_outputs", {29'b0, mul_A, mul_B, mul_A_sign, mul_B_sign, mul_HALF_0}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Corner products.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0); wait_idle();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1); wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_idle();
    issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0); wait_idle();
    issue(32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_idle();
    check("corner_ref_unsigned", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0), 64'hFFFF_FFFE_0000_0001);

    // Slice drive per state, with the input operands scrambled after accept.
    slice_exp[0] = {16'h5678, 16'hDEF0, 1'b0, 1'b0};
    slice_exp[1] = {16'h1234, 16'hDEF0, 1'b1, 1'b0};
    slice_exp[2] = {16'h5678, 16'h9ABC, 1'b0, 1'b1};
    slice_exp[3] = {16'h1234, 16'h9ABC, 1'b1, 1'b1};
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("slice_S%0d", s), {30'b0, mul_A, mul_B, mul_A_sign, mul_B_sign}, {30'b0, slice_exp[s]});
      check($sformatf("busy_S%0d", s), {63'b0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    wait_idle();

    // Backpressure in DONE: hold, ignore new requests, then release.
    rdy_force = 1'b0;
    @(posedge clk); #3;
    bp_exp = ref_prod(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) fail("bp_out_valid_timeout");
    in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      check("bp_hold_valid", {63'b0, out_valid}, 64'd1);
      check("bp_hold_p", p, bp_exp);
      check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    check("bp_release_handshake", {62'b0, out_valid, out_ready}, 64'd3);
    @(negedge clk);
    check("bp_idle_after_release", {62'b0, in_ready, out_valid}, 64'd2);
    @(posedge clk); #1;

    // Reset pulse during S2 discards the operation.
    issue(32'hCAFE_F00D, 32'h1234_4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_in_ready_busy", {62'b0, in_ready, busy}, 64'd2);
    check("midreset_p", p, 64'd0);
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    @(posedge clk); #1;
    issue(32'd3, 32'd5, 1'b0, 1'b0); wait_idle();

    // Randomized traffic with random request gaps and consumer stalls.
    rdy_rand = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(rand_word(), rand_word(), 1'($urandom), 1'($urandom));
    end
    wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
